mic1_regfile: RTL and testbench

MIC1_REGFILE -- requirements
Module: mic1_regfile

---
 rtl/mic1_pkg.sv | 33 +++
 rtl/mic1_bbus_mux.sv | 33 +++
 rtl/mic1_regfile.sv | 124 ++++++++++++
 tb/tb_mic1_regfile.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mic1_pkg.sv
// Shared definitions for the MIC-1 datapath: B-bus source encoding,
// C-bus enable bit positions and register reset values.
package mic1_pkg;

  typedef enum logic [3:0] {
    B_MDR  = 4'd0,
    B_PC   = 4'd1,
    B_MBR  = 4'd2,
    B_MBRU = 4'd3,
    B_SP   = 4'd4,
    B_LV   = 4'd5,
    B_CPP  = 4'd6,
    B_TOS  = 4'd7,
    B_OPC  = 4'd8
  } b_sel_e;

  localparam int C_MAR = 0;
  localparam int C_MDR = 1;
  localparam int C_PC  = 2;
  localparam int C_SP  = 3;
  localparam int C_LV  = 4;
  localparam int C_CPP = 5;
  localparam int C_TOS = 6;
  localparam int C_OPC = 7;
  localparam int C_H   = 8;
  localparam int C_EN_W = 9;

  localparam logic [31:0] RST_PC  = 32'h0000_0000;
  localparam logic [31:0] RST_SP  = 32'h0000_8000;
  localparam logic [31:0] RST_LV  = 32'h0000_8000;
  localparam logic [31:0] RST_CPP = 32'h0000_4000;

endpackage

// File: rtl/mic1_bbus_mux.sv
// B-bus source select for the MIC-1 datapath; unused codes drive zero.
module mic1_bbus_mux
  import mic1_pkg::*;
(
  input  logic [3:0]  b_sel,
  input  logic [31:0] mdr,
  input  logic [31:0] pc,
  input  logic [7:0]  mbr,
  input  logic [31:0] sp,
  input  logic [31:0] lv,
  input  logic [31:0] cpp,
  input  logic [31:0] tos,
  input  logic [31:0] opc,
  output logic [31:0] b_bus
);

  always_comb begin
    b_bus = 32'h0;
    case (b_sel_e'(b_sel))
      B_MDR:   b_bus = mdr;
      B_PC:    b_bus = pc;
      B_MBR:   b_bus = {{24{mbr[7]}}, mbr};
      B_MBRU:  b_bus = {24'h0, mbr};
      B_SP:    b_bus = sp;
      B_LV:    b_bus = lv;
      B_CPP:   b_bus = cpp;
      B_TOS:   b_bus = tos;
      B_OPC:   b_bus = opc;
      default: b_bus = 32'h0;
    endcase
  end

endmodule

// File: rtl/mic1_regfile.sv
// MIC-1 register file: nine C-bus writable registers, MBR, ALU flags and
// the one-cycle-latency memory read/fetch tracking.
module mic1_regfile
  import mic1_pkg::*;
#(
  parameter logic [31:0] PC_RESET  = RST_PC,
  parameter logic [31:0] SP_RESET  = RST_SP,
  parameter logic [31:0] LV_RESET  = RST_LV,
  parameter logic [31:0] CPP_RESET = RST_CPP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        b_sel,
  input  logic [C_EN_W-1:0] c_en,
  input  logic [31:0]       c_bus,
  input  logic              rd,
  input  logic              wr,
  input  logic              fetch,
  input  logic              alu_n,
  input  logic              alu_z,
  input  logic [31:0]       mem_rdata,
  input  logic [7:0]        mem_fdata,
  output logic [31:0]       a_bus,
  output logic [31:0]       b_bus,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [31:0]       mem_pc,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              mem_fetch,
  output logic              n_flag,
  output logic              z_flag,
  output logic [7:0]        mbr_out,
  output logic              rw_err
);

  logic [31:0] mar_q, mar_d, mdr_q, mdr_d, pc_q, pc_d, sp_q, sp_d;
  logic [31:0] lv_q, lv_d, cpp_q, cpp_d, tos_q, tos_d, opc_q, opc_d;
  logic [31:0] h_q, h_d;
  logic [7:0]  mbr_q, mbr_d;
  logic        n_q, n_d, z_q, z_d;
  logic        rd_pend_q, rd_pend_d, f_pend_q, f_pend_d;

  always_comb begin
    mar_d     = c_en[C_MAR] ? c_bus : mar_q;
    pc_d      = c_en[C_PC]  ? c_bus : pc_q;
    sp_d      = c_en[C_SP]  ? c_bus : sp_q;
    lv_d      = c_en[C_LV]  ? c_bus : lv_q;
    cpp_d     = c_en[C_CPP] ? c_bus : cpp_q;
    tos_d     = c_en[C_TOS] ? c_bus : tos_q;
    opc_d     = c_en[C_OPC] ? c_bus : opc_q;
    h_d       = c_en[C_H]   ? c_bus : h_q;
    // Returning read data beats a same-edge C-bus write to MDR.
    if (rd_pend_q)        mdr_d = mem_rdata;
    else if (c_en[C_MDR]) mdr_d = c_bus;
    else                  mdr_d = mdr_q;
    mbr_d     = f_pend_q ? mem_fdata : mbr_q;
    rd_pend_d = rd;
    f_pend_d  = fetch;
    n_d       = alu_n;
    z_d       = alu_z;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mar_q     <= 32'h0;
      mdr_q     <= 32'h0;
      pc_q      <= PC_RESET;
      sp_q      <= SP_RESET;
      lv_q      <= LV_RESET;
      cpp_q     <= CPP_RESET;
      tos_q     <= 32'h0;
      opc_q     <= 32'h0;
      h_q       <= 32'h0;
      mbr_q     <= 8'h00;
      n_q       <= 1'b0;
      z_q       <= 1'b1;
      rd_pend_q <= 1'b0;
      f_pend_q  <= 1'b0;
    end else begin
      mar_q     <= mar_d;
      mdr_q     <= mdr_d;
      pc_q      <= pc_d;
      sp_q      <= sp_d;
      lv_q      <= lv_d;
      cpp_q     <= cpp_d;
      tos_q     <= tos_d;
      opc_q     <= opc_d;
      h_q       <= h_d;
      mbr_q     <= mbr_d;
      n_q       <= n_d;
      z_q       <= z_d;
      rd_pend_q <= rd_pend_d;
      f_pend_q  <= f_pend_d;
    end
  end

  mic1_bbus_mux u_bbus_mux (
    .b_sel (b_sel),
    .mdr   (mdr_q),
    .pc    (pc_q),
    .mbr   (mbr_q),
    .sp    (sp_q),
    .lv    (lv_q),
    .cpp   (cpp_q),
    .tos   (tos_q),
    .opc   (opc_q),
    .b_bus (b_bus)
  );

  assign a_bus     = h_q;
  assign mem_addr  = mar_q;
  assign mem_wdata = mdr_q;
  assign mem_pc    = pc_q;
  assign mem_rd    = rd;
  // A simultaneous read and write is treated as a microcode error: read only.
  assign mem_wr    = wr & ~rd;
  assign rw_err    = rd & wr;
  assign mem_fetch = fetch;
  assign n_flag    = n_q;
  assign z_flag    = z_q;
  assign mbr_out   = mbr_q;

endmodule

// File: tb/tb_mic1_regfile.sv
// Scoreboard bench for mic1_regfile: directed scenarios plus random traffic
// checked against a register-array reference model.
module tb_mic1_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  b_sel;
  logic [8:0]  c_en;
  logic [31:0] c_bus;
  logic        rd, wr, fetch, alu_n, alu_z;
  logic [31:0] mem_rdata;
  logic [7:0]  mem_fdata;
  logic [31:0] a_bus, b_bus, mem_addr, mem_wdata, mem_pc;
  logic        mem_rd, mem_wr, mem_fetch, n_flag, z_flag, rw_err;
  logic [7:0]  mbr_out;

  always #5 clk = ~clk;

  mic1_regfile dut (
    .clk(clk), .rst(rst), .b_sel(b_sel), .c_en(c_en), .c_bus(c_bus),
    .rd(rd), .wr(wr), .fetch(fetch), .alu_n(alu_n), .alu_z(alu_z),
    .mem_rdata(mem_rdata), .mem_fdata(mem_fdata),
    .a_bus(a_bus), .b_bus(b_bus), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_pc(mem_pc), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_fetch(mem_fetch),
    .n_flag(n_flag), .z_flag(z_flag), .mbr_out(mbr_out), .rw_err(rw_err)
  );

  typedef struct {
    bit          chk;
    logic [31:0] b, a, addr, wdata, pc;
    logic        mrd, mwr, mf, n, z, err;
    logic [7:0]  mbr;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference state: r[i] is the register written by c_en bit i.
  logic [31:0] r [0:8];
  logic [7:0]  m_mbr;
  logic        m_n, m_z;
  bit          rd_prev, fetch_prev, m_valid = 0;

  function automatic logic [31:0] model_b(input logic [3:0] sel);
    case (sel)
      4'd0: return r[1];
      4'd1: return r[2];
      4'd2: return {{24{m_mbr[7]}}, m_mbr};
      4'd3: return {24'h0, m_mbr};
      4'd4: return r[3];
      4'd5: return r[4];
      4'd6: return r[5];
      4'd7: return r[6];
      4'd8: return r[7];
      default: return 32'h0;
    endcase
  endfunction

  task automatic cycle(input bit rs, input logic [3:0] bs, input logic [8:0] ce,
                       input logic [31:0] cb, input bit r_, input bit w_,
                       input bit f_, input bit an, input bit az,
                       input logic [31:0] rdat, input logic [7:0] fdat);
    exp_t e;
    @(posedge clk); #1;
    rst = rs; b_sel = bs; c_en = ce; c_bus = cb; rd = r_; wr = w_;
    fetch = f_; alu_n = an; alu_z = az; mem_rdata = rdat; mem_fdata = fdat;
    e.chk = m_valid;
    e.b = model_b(bs); e.a = r[8]; e.addr = r[0]; e.wdata = r[1]; e.pc = r[2];
    e.mrd = r_; e.mwr = w_ && !r_; e.mf = f_; e.err = r_ && w_;
    e.n = m_n; e.z = m_z; e.mbr = m_mbr;
    exp_q.push_back(e);
    if (rs) begin
      for (int i = 0; i < 9; i++) r[i] = 32'h0;
      r[2] = 32'h0000_0000; r[3] = 32'h0000_8000;
      r[4] = 32'h0000_8000; r[5] = 32'h0000_4000;
      m_mbr = 8'h00; m_n = 0; m_z = 1; rd_prev = 0; fetch_prev = 0;
      m_valid = 1;
    end else begin
      for (int i = 0; i < 9; i++) if (ce[i]) r[i] = cb;
      if (rd_prev) r[1] = rdat;
      if (fetch_prev) m_mbr = fdat;
      m_n = an; m_z = az; rd_prev = r_; fetch_prev = f_;
    end
  endtask

  task automatic idle(input logic [3:0] bs);
    cycle(0, bs, 9'h0, 32'h0, 0, 0, 0, 0, 0, $urandom, 8'($urandom));
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.chk) begin
          cmp("b_bus", b_bus, e.b);
          cmp("a_bus", a_bus, e.a);
          cmp("mem_addr", mem_addr, e.addr);
          cmp("mem_wdata", mem_wdata, e.wdata);
          cmp("mem_pc", mem_pc, e.pc);
          cmp("mem_rd", 32'(mem_rd), 32'(e.mrd));
          cmp("mem_wr", 32'(mem_wr), 32'(e.mwr));
          cmp("mem_fetch", 32'(mem_fetch), 32'(e.mf));
          cmp("rw_err", 32'(rw_err), 32'(e.err));
          cmp("n_flag", 32'(n_flag), 32'(e.n));
          cmp("z_flag", 32'(z_flag), 32'(e.z));
          cmp("mbr_out", 32'(mbr_out), 32'(e.mbr));
        end
      end
    end
  end

  initial begin : driver
    int wait_cnt;
    rst = 1; b_sel = 0; c_en = 0; c_bus = 0; rd = 0; wr = 0; fetch = 0;
    alu_n = 0; alu_z = 0; mem_rdata = 0; mem_fdata = 0;
    for (int i = 0; i < 9; i++) r[i] = 32'hx;
    m_mbr = 8'hx; m_n = 1'bx; m_z = 1'bx;

    // Reset, then PC/SP reset values and flags.
    cycle(1, 4'd1, 9'h0, 32'h0, 0, 0, 0, 0, 0, 32'h0, 8'h0);
    cycle(1, 4'd1, 9'h1FF, 32'hFFFF_FFFF, 1, 0, 1, 1, 0, 32'h5, 8'h5);
    idle(4'd1);
    idle(4'd4);

    // Broadcast write to all nine registers, then read each back.
    cycle(0, 4'd0, 9'h1FF, 32'h1234_5678, 0, 0, 0, 0, 0, 32'h0, 8'h0);
    for (int s = 0; s < 16; s++) idle(4'(s));

    // Fetch of 8'h80 then signed and unsigned MBR views.
    cycle(0, 4'd0, 9'h0, 32'h0, 0, 0, 1, 0, 0, 32'h0, 8'h00);
    cycle(0, 4'd0, 9'h0, 32'h0, 0, 0, 0, 0, 0, 32'h0, 8'h80);
    idle(4'd2);
    idle(4'd3);

    // Read collides with a C-bus write of MDR: memory data wins.
    cycle(0, 4'd0, 9'h0, 32'h0, 1, 0, 0, 0, 0, 32'h0, 8'h0);
    cycle(0, 4'd0, 9'h002, 32'h1, 0, 0, 0, 0, 0, 32'hDEAD_BEEF, 8'h0);
    idle(4'd0);

    // Read and write together, then a lone write.
    cycle(0, 4'd0, 9'h0, 32'h0, 1, 1, 0, 0, 0, 32'h0, 8'h0);
    cycle(0, 4'd0, 9'h0, 32'h0, 0, 1, 0, 0, 0, 32'hAAAA_5555, 8'h0);
    idle(4'd0);

    // Back-to-back reads and fetches, distinct data each cycle.
    cycle(0, 4'd0, 9'h0, 32'h0, 1, 0, 1, 1, 1, 32'h0, 8'h0);
    cycle(0, 4'd0, 9'h0, 32'h0, 1, 0, 1, 0, 1, 32'h1111_1111, 8'h11);
    cycle(0, 4'd0, 9'h0, 32'h0, 0, 0, 0, 1, 0, 32'h2222_2222, 8'h22);
    idle(4'd0);

    // Read pending across reset must be dropped.
    cycle(0, 4'd0, 9'h0, 32'h0, 1, 0, 1, 0, 0, 32'h0, 8'h0);
    cycle(1, 4'd0, 9'h0, 32'h0, 0, 0, 0, 0, 0, 32'hDEAD_BEEF, 8'h77);
    cycle(0, 4'd0, 9'h0, 32'h0, 0, 0, 0, 0, 0, 32'hCAFE_F00D, 8'h66);
    idle(4'd2);

    for (int k = 0; k < 600; k++) begin
      cycle(($urandom_range(0, 39) == 0), 4'($urandom_range(0, 15)),
            9'($urandom), $urandom, $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom, 8'($urandom));
    end

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
